herald_io_bridge: RTL and testbench
===================================

HERALD_IO_BRIDGE -- requirements
Module: herald_io_bridge

Interface
REQ-001 Parameter NUM_REGS, default 8, number of core registers; legal range 2..128.
REQ-002 Parameter DATA_W, default 16, register width; legal values 8, 16, 24, 32; BYTES = DATA_W/8.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth; legal range 2..4.
REQ-004 clk  in  1  sole clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ena  in  1  design-selected enable.
REQ-007 ui_in  in  8  [0] host strobe toggle (STB), [1] abort level, [7:2] unused.
REQ-008 uio_in  in  8  host command/data byte.
REQ-009 uo_out  out  8  status byte; fields per REQ-021.
REQ-010 uio_out  out  8  read-data byte.
REQ-011 uio_oe  out  8  uio direction; 8'hFF while reading, 8'h00 otherwise.
REQ-012 reg_q  out  NUM_REGS*DATA_W  written register file; reg i at [i*DATA_W +: DATA_W].
REQ-013 reg_wr  out  NUM_REGS  one-cycle write pulse per register.
REQ-014 reg_d  in  NUM_REGS*DATA_W  core readback values, same packing as reg_q.

Function
REQ-015 Pass ui_in[0] and ui_in[1] through SYNC_STAGES flops; an event is any change of synced STB versus its previous registered value.
REQ-016 On an event, sample raw uio_in in the event cycle; the host holds uio_in stable from SYNC_STAGES+1 cycles before a toggle until ACK changes.
REQ-017 Every accepted event toggles ACK (uo_out[0]) exactly SYNC_STAGES+1 clk cycles after the ui_in[0] toggle.
REQ-018 States: IDLE, WDATA, RDATA. In IDLE, the event byte is a command: bit7 = 1 read, 0 write; bits[6:0] = addr.
REQ-019 Command with addr >= NUM_REGS: ACK toggles, ERR (uo_out[2]) sets sticky, state stays IDLE; the next in-range command clears ERR.
REQ-020 Write: IDLE->WDATA; collect BYTES bytes MSB-first; on the last byte update reg_q[addr] and pulse reg_wr[addr] for one cycle in the same cycle ACK toggles; then go to IDLE.
REQ-021 uo_out = {2'b00, state[1:0], rd_active, err, busy, ack}; busy = state != IDLE; rd_active = state == RDATA; IDLE=0, WDATA=1, RDATA=2.
REQ-022 Read: on the command event, capture reg_d[addr] into a shift register, enter RDATA, set uio_oe=8'hFF and drive the MSB byte on uio_out.
REQ-023 In RDATA, each event shifts to the next byte; the event after the last byte returns the block to IDLE with uio_oe=8'h00 and uio_out=8'h00; uio_in is ignored in RDATA.
REQ-024 Synced abort high: go to IDLE next cycle; discard partial write data; no reg_wr pulse; uio_oe=8'h00; no ACK toggle.
REQ-025 Abort and event in the same cycle: abort wins and the event is discarded.
REQ-026 ena low: ignore events, force IDLE, hold uio_oe=8'h00; reg_q and err are retained; the edge-detect history keeps tracking so no spurious event occurs on ena rise.
REQ-027 reg_wr has at most one bit set per cycle; reg_q changes only on a completed write.

Reset
REQ-028 rst_n low immediately clears all state: state=IDLE; reg_q, reg_wr, ack, err, the shift register, and the synchroniser chains all zero.
REQ-029 During reset: uo_out=8'h00, uio_out=8'h00, uio_oe=8'h00.
REQ-030 Reset asserted mid-transaction abandons the transaction; no reg_wr pulse.
REQ-031 Release is synchronised by the system; the first event is possible SYNC_STAGES+1 cycles after release.

Structure
REQ-032 Package herald_bridge_pkg holds the state enum, uo_out bit positions, read-opcode bit index and the legal DATA_W set.
REQ-033 Sub-module herald_toggle_sync (synchroniser plus change detect, parameter SYNC_STAGES) is used for STB; abort uses the same synchroniser without the detect output.
REQ-034 All behaviour is on the single clk; no derived clocks or latches.

Verification (defaults: NUM_REGS=8, DATA_W=16, SYNC_STAGES=2)
REQ-035 Write: cmd 0x03, then 0xBE, then 0xEF -> reg_q[3]=16'hBEEF; one reg_wr[3] pulse; three ACK toggles, each 3 cycles after its STB toggle.
REQ-036 Read: reg_d[5]=16'h1234, cmd 0x85 -> uio_oe=8'hFF, uio_out=8'h12; toggle -> 8'h34; toggle -> uio_oe=8'h00, busy=0.
REQ-037 Bad address: cmd 0x0A -> err=1, busy=0, ACK toggles; then cmd 0x01 -> err=0.
REQ-038 Abort: cmd 0x02, byte 0x55, abort high -> IDLE; reg_q[2] unchanged; no reg_wr; abort plus simultaneous toggle -> no ACK change.
REQ-039 Reset mid-read in RDATA: rst_n low -> uio_oe=8'h00 and uo_out=8'h00 without waiting for clk; all reg_q zero.
REQ-040 ena=0: three STB toggles -> no ACK change, reg_q stable; ena=1 -> no spurious event.

Source files
------------

// File: rtl/herald_bridge_pkg.sv
// Shared types and constants for the herald host-to-core register bridge.
// Holds the FSM encoding, status-byte layout and legal register widths.
package herald_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_RDATA = 2'd2
   } bridge_state_t;

   localparam int UO_ACK      = 0;
   localparam int UO_BUSY     = 1;
   localparam int UO_ERR      = 2;
   localparam int UO_RDACT    = 3;
   localparam int UO_STATE_LO = 4;
   localparam int UO_STATE_HI = 5;

   localparam int RD_OP_BIT = 7;

   function automatic bit data_w_legal(input int w);
      return (w == 8) || (w == 16) || (w == 24) || (w == 32);
   endfunction

endpackage

// File: rtl/herald_toggle_sync.sv
// Multi-flop synchroniser for one asynchronous host line.
// The change output flags any difference between the synced value and its previous sample.
module herald_toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic change
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign q      = chain[SYNC_STAGES-1];
   assign change = q ^ prev;

endmodule

// File: rtl/herald_io_bridge.sv
// Toggle-handshake byte bridge between an 8-bit host port and a bank of core registers.
// Commands select read or write; data moves MSB-first, one byte per strobe toggle.
module herald_io_bridge
   import herald_bridge_pkg::*;
#(
   parameter int NUM_REGS    = 8,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic [7:0]                   ui_in,
   input  logic [7:0]                   uio_in,
   output logic [7:0]                   uo_out,
   output logic [7:0]                   uio_out,
   output logic [7:0]                   uio_oe,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          reg_wr,
   input  logic [NUM_REGS*DATA_W-1:0]   reg_d
);

   localparam int         BYTES     = DATA_W / 8;
   localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

   if (!data_w_legal(DATA_W)) begin : g_bad_data_w
      $error("herald_io_bridge: DATA_W must be 8, 16, 24 or 32");
   end

   bridge_state_t       state, state_next;
   logic                ack, ack_next, err, err_next, wr_en;
   logic [1:0]          cnt, cnt_next;
   logic [6:0]          addr, addr_next;
   logic [DATA_W-1:0]   shift, shift_next, rd_word;
   logic [DATA_W+7:0]   wcat;
   logic                stb_s, stb_event, abort_s, abort_change_unused;
   logic                unused_ui;

   herald_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
      .clk(clk), .rst_n(rst_n), .d(ui_in[0]), .q(stb_s), .change(stb_event)
   );

   herald_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_abort_sync (
      .clk(clk), .rst_n(rst_n), .d(ui_in[1]), .q(abort_s), .change(abort_change_unused)
   );

   assign unused_ui = &{1'b0, ui_in[7:2], stb_s};
   assign wcat      = {shift, uio_in};

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (uio_in[6:0] == 7'(i)) rd_word = reg_d[i*DATA_W +: DATA_W];
      end
   end

   // Abort and disable both take priority over any strobe event in the same cycle.
   always_comb begin
      state_next = state;
      ack_next   = ack;
      err_next   = err;
      cnt_next   = cnt;
      addr_next  = addr;
      shift_next = shift;
      wr_en      = 1'b0;
      if (!ena || abort_s) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else if (stb_event) begin
         ack_next = ~ack;
         case (state)
            ST_IDLE: begin
               cnt_next = '0;
               if (int'(uio_in[6:0]) >= NUM_REGS) begin
                  err_next = 1'b1;
               end else begin
                  err_next  = 1'b0;
                  addr_next = uio_in[6:0];
                  if (uio_in[RD_OP_BIT]) begin
                     shift_next = rd_word;
                     state_next = ST_RDATA;
                  end else begin
                     state_next = ST_WDATA;
                  end
               end
            end
            ST_WDATA: begin
               shift_next = wcat[DATA_W-1:0];
               if (cnt == LAST_BYTE) begin
                  wr_en      = 1'b1;
                  cnt_next   = '0;
                  state_next = ST_IDLE;
               end else begin
                  cnt_next = cnt + 2'd1;
               end
            end
            ST_RDATA: begin
               if (cnt == LAST_BYTE) begin
                  shift_next = '0;
                  cnt_next   = '0;
                  state_next = ST_IDLE;
               end else begin
                  shift_next = shift << 8;
                  cnt_next   = cnt + 2'd1;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack   <= 1'b0;
         err   <= 1'b0;
         cnt   <= '0;
         addr  <= '0;
         shift <= '0;
      end else begin
         ack   <= ack_next;
         err   <= err_next;
         cnt   <= cnt_next;
         addr  <= addr_next;
         shift <= shift_next;
      end
   end

   // The write pulse and register update land on the same edge as the final ACK toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q  <= '0;
         reg_wr <= '0;
      end else begin
         reg_wr <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && addr == 7'(i)) begin
               reg_q[i*DATA_W +: DATA_W] <= wcat[DATA_W-1:0];
               reg_wr[i]                 <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      uo_out                          = '0;
      uo_out[UO_ACK]                  = ack;
      uo_out[UO_BUSY]                 = (state != ST_IDLE);
      uo_out[UO_ERR]                  = err;
      uo_out[UO_RDACT]                = (state == ST_RDATA);
      uo_out[UO_STATE_HI:UO_STATE_LO] = state;
   end

   assign uio_oe  = (ena && state == ST_RDATA) ? 8'hFF : 8'h00;
   assign uio_out = (ena && state == ST_RDATA) ? shift[DATA_W-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_herald_io_bridge.sv
// Directed plus randomized bench for herald_io_bridge against a transaction-level model.
// The model tracks register contents, ACK parity and the sticky error bit.
module tb_herald_io_bridge;

   localparam int NR    = 8;
   localparam int DW    = 16;
   localparam int SYNC  = 2;
   localparam int BYTES = DW / 8;

   logic             clk, rst_n, ena;
   logic [7:0]       ui_in, uio_in, uo_out, uio_out, uio_oe;
   logic [NR*DW-1:0] reg_q, reg_d;
   logic [NR-1:0]    reg_wr;

   logic [DW-1:0]    m_q [NR];
   logic [DW-1:0]    m_d [NR];
   logic             exp_ack, exp_err;
   int               n_compared, n_mismatch;

   herald_io_bridge #(.NUM_REGS(NR), .DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
      .reg_q(reg_q), .reg_wr(reg_wr), .reg_d(reg_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatch++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] modelQ();
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_q[i];
      return v;
   endfunction

   function automatic logic [7:0] expUo(input int st);
      logic [1:0] s;
      s = 2'(st);
      return {2'b00, s, (st == 2), exp_err, (st != 0), exp_ack};
   endfunction

   task automatic setRd(input int i, input logic [DW-1:0] v);
      m_d[i] = v;
      reg_d[i*DW +: DW] = v;
   endtask

   // Host side of one handshake: present byte, toggle STB, expect ACK exactly SYNC+1 cycles later.
   task automatic applyStimulus(input logic [7:0] b, input bit accept);
      uio_in = b;
      repeat (SYNC + 1) @(negedge clk);
      ui_in[0] = ~ui_in[0];
      repeat (SYNC) @(negedge clk);
      checkOutput("ack_hold", 128'(uo_out[0]), 128'(exp_ack));
      @(negedge clk);
      if (accept) exp_ack = ~exp_ack;
      checkOutput("ack_edge", 128'(uo_out[0]), 128'(exp_ack));
   endtask

   task automatic doWrite(input logic [6:0] a, input logic [DW-1:0] d);
      applyStimulus({1'b0, a}, 1'b1);
      if (int'(a) >= NR) begin
         exp_err = 1'b1;
         checkOutput("wr_bad_uo", 128'(uo_out), 128'(expUo(0)));
         return;
      end
      exp_err = 1'b0;
      checkOutput("wr_cmd_uo", 128'(uo_out), 128'(expUo(1)));
      for (int k = 0; k < BYTES; k++) begin
         applyStimulus(d[8*(BYTES-1-k) +: 8], 1'b1);
         if (k < BYTES - 1) checkOutput("wr_mid_regq", reg_q, modelQ());
      end
      checkOutput("wr_pulse", 128'(reg_wr), 128'(8'(1) << a));
      m_q[a] = d;
      checkOutput("wr_regq", reg_q, modelQ());
      checkOutput("wr_done_uo", 128'(uo_out), 128'(expUo(0)));
      @(negedge clk);
      checkOutput("wr_pulse_end", 128'(reg_wr), 128'(0));
   endtask

   task automatic doRead(input logic [6:0] a);
      logic [DW-1:0] v;
      applyStimulus({1'b1, a}, 1'b1);
      if (int'(a) >= NR) begin
         exp_err = 1'b1;
         checkOutput("rd_bad_uo", 128'(uo_out), 128'(expUo(0)));
         checkOutput("rd_bad_oe", 128'(uio_oe), 128'(0));
         return;
      end
      exp_err = 1'b0;
      v = m_d[a];
      for (int k = 0; k < BYTES; k++) begin
         if (k > 0) applyStimulus(8'($urandom), 1'b1);
         checkOutput("rd_oe", 128'(uio_oe), 128'(8'hFF));
         checkOutput("rd_byte", 128'(uio_out), 128'((v >> (8 * (BYTES - 1 - k))) & 16'h00FF));
         checkOutput("rd_uo", 128'(uo_out), 128'(expUo(2)));
      end
      applyStimulus(8'($urandom), 1'b1);
      checkOutput("rd_end_oe", 128'(uio_oe), 128'(0));
      checkOutput("rd_end_out", 128'(uio_out), 128'(0));
      checkOutput("rd_end_uo", 128'(uo_out), 128'(expUo(0)));
   endtask

   task automatic modelReset();
      for (int i = 0; i < NR; i++) m_q[i] = '0;
      exp_ack = 1'b0;
      exp_err = 1'b0;
   endtask

   initial begin
      n_compared = 0;
      n_mismatch = 0;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      reg_d  = '0;
      for (int i = 0; i < NR; i++) m_d[i] = '0;
      modelReset();

      #12;
      checkOutput("rst_uo", 128'(uo_out), 128'(0));
      checkOutput("rst_oe", 128'(uio_oe), 128'(0));
      checkOutput("rst_out", 128'(uio_out), 128'(0));
      checkOutput("rst_regq", reg_q, 128'(0));
      checkOutput("rst_wr", 128'(reg_wr), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SYNC + 2) @(negedge clk);

      $display("[TB] directed write / read / bad address");
      doWrite(7'h03, 16'hBEEF);
      setRd(5, 16'h1234);
      doRead(7'h05);
      doWrite(7'h0A, 16'h0000);
      doWrite(7'h01, 16'h0F0F);
      doRead(7'h7F);
      doRead(7'h02);

      $display("[TB] abort mid-write");
      applyStimulus(8'h02, 1'b1);
      exp_err = 1'b0;
      applyStimulus(8'h55, 1'b1);
      ui_in[1] = 1'b1;
      repeat (SYNC + 1) @(negedge clk);
      checkOutput("abort_uo", 128'(uo_out), 128'(expUo(0)));
      checkOutput("abort_wr", 128'(reg_wr), 128'(0));
      checkOutput("abort_regq", reg_q, modelQ());
      applyStimulus(8'h03, 1'b0);
      ui_in[1] = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
      ui_in[1] = 1'b1;
      ui_in[0] = ~ui_in[0];
      repeat (SYNC + 1) @(negedge clk);
      checkOutput("abort_sim_ack", 128'(uo_out[0]), 128'(exp_ack));
      ui_in[1] = 1'b0;
      repeat (SYNC + 3) @(negedge clk);
      checkOutput("abort_after_uo", 128'(uo_out), 128'(expUo(0)));
      doWrite(7'h02, 16'hA5C3);

      $display("[TB] enable low");
      ena = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(8'h04, 1'b0);
      checkOutput("ena_regq", reg_q, modelQ());
      checkOutput("ena_uo", 128'(uo_out), 128'(expUo(0)));
      ena = 1'b1;
      repeat (SYNC + 3) @(negedge clk);
      checkOutput("ena_rise_uo", 128'(uo_out), 128'(expUo(0)));
      doWrite(7'h06, 16'h7E81);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 16; n++) begin
         logic [6:0] a;
         a = 7'($urandom_range(0, 11));
         if ($urandom_range(0, 1) == 1) begin
            if (int'(a) < NR) setRd(int'(a), DW'($urandom));
            doRead(a);
         end else begin
            doWrite(a, DW'($urandom));
         end
      end

      $display("[TB] reset during read");
      setRd(5, 16'hCAFE);
      applyStimulus(8'h85, 1'b1);
      exp_err = 1'b0;
      checkOutput("rr_oe_before", 128'(uio_oe), 128'(8'hFF));
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rr_oe", 128'(uio_oe), 128'(0));
      checkOutput("rr_uo", 128'(uo_out), 128'(0));
      checkOutput("rr_out", 128'(uio_out), 128'(0));
      checkOutput("rr_regq", reg_q, 128'(0));
      ui_in = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SYNC + 2) @(negedge clk);
      checkOutput("rr_wr", 128'(reg_wr), 128'(0));
      doWrite(7'h04, 16'h1357);
      doRead(7'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
